chord_scheduler: RTL and testbench
==================================

CHORD_SCHEDULER -- requirements
Module: chord_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 3: number of external sine_reader voices sequenced.
REQ-002 Parameter TIMEOUT, default 16: maximum WAIT cycles per voice before the voice is abandoned.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 generate_next  input  1  request for one mixed sample; one-cycle pulse from codec side.
REQ-006 voice_en  input  NUM_VOICES  per-voice enable; bit i gates voice i.
REQ-007 voice_gen  output  NUM_VOICES  one-cycle pulse to reader i's generate_next.
REQ-008 voice_ready  input  NUM_VOICES  reader i's sample_ready.
REQ-009 voice_samples  input  16*NUM_VOICES  reader i's signed sample in bits [16i+15:16i].
REQ-010 mix_sample  output  16  signed mixed sample, held between updates.
REQ-011 mix_ready  output  1  one-cycle pulse; mix_sample valid from this cycle onward.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 overrun  output  1  sticky; a request arrived while busy.
REQ-014 timeout_err  output  1  sticky; some voice hit TIMEOUT.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE: generate_next=1 -> latch voice_en to en_q, clear accumulator; go to ISSUE at lowest enabled index; if en_q==0, go to DONE.
REQ-017 ISSUE: exactly one cycle; voice_gen[cur]=1, all other bits 0; next state WAIT; WAIT counter cleared.
REQ-018 WAIT: voice_ready[cur]=1 -> accumulator += sign-extend(voice_samples[cur]) to 18 bits; then ISSUE at next enabled index above cur, else DONE.
REQ-019 WAIT: voice_ready bits other than cur are ignored; voice_ready in any other state is ignored.
REQ-020 WAIT: counter reaches TIMEOUT with no ready -> voice contributes 0, timeout_err set, advance per REQ-018.
REQ-021 DONE: one cycle; mix_ready=1; mix_sample = accumulator[17:2] (arithmetic divide by 4, no saturation needed for 3 voices); next state IDLE.
REQ-022 voice_gen is decoded from state; it is never high outside ISSUE.
REQ-023 voice_en changes after acceptance have no effect until the next request.
REQ-024 generate_next while busy, including in DONE, is dropped and sets overrun; it does not queue.
REQ-025 Timing against readers with 3-cycle latency: request sampled at edge 0 -> ISSUE in cycle 1 -> ready in cycle 4 -> next ISSUE in cycle 5; mix_ready in cycle 1+4*N for N enabled voices.
REQ-026 All voices disabled: mix_ready in cycle 1, mix_sample=0.
REQ-027 Accumulator is 18-bit signed; wrap-around is impossible for NUM_VOICES<=4.

Reset
REQ-028 reset=1 asynchronously forces IDLE, voice_gen=0, mix_ready=0, busy=0, mix_sample=0, accumulator=0, overrun=0, timeout_err=0, en_q=0.
REQ-029 Reset mid-operation abandons the sequence; no mix_ready follows; the first request after release starts normally.
REQ-030 overrun and timeout_err clear only on reset.

Verification
REQ-031 voice_en=3'b111, model readers returning 0x1000, 0x2000, 0x0800 with 3-cycle latency, one request -> voice_gen pulses 001, 010, 100 in cycles 1, 5, 9; mix_ready in cycle 13; mix_sample=0x0E00.
REQ-032 voice_en=3'b101, samples 0x8000 and 0x8000 -> only voices 0 and 2 pulsed; mix_ready in cycle 9; mix_sample=0xC000.
REQ-033 voice_en=0, request -> mix_ready in cycle 1, mix_sample=0, no voice_gen pulse.
REQ-034 Voice 1 model never returns ready, voices 0 and 2 return 0x0400 -> timeout_err=1 after 16 WAIT cycles on voice 1; mix_ready still pulses; mix_sample=0x0200.
REQ-035 Second request in cycle 3 of a 3-voice sequence -> overrun=1; exactly one mix_ready; busy stays high through the sequence.
REQ-036 reset pulsed in cycle 6 of a 3-voice sequence -> all outputs 0 immediately; no mix_ready; next request gives the REQ-031 timing.

Source files
------------

// File: rtl/chord_scheduler.sv
// chord_scheduler: sequences external sine readers one voice at a time and mixes their samples into one output.
module chord_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    generate_next,
  input  logic [NUM_VOICES-1:0]   voice_en,
  output logic [NUM_VOICES-1:0]   voice_gen,
  input  logic [NUM_VOICES-1:0]   voice_ready,
  input  logic [16*NUM_VOICES-1:0] voice_samples,
  output logic [15:0]             mix_sample,
  output logic                    mix_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic                    timeout_err
);
  localparam int IW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [IW-1:0] cur, first_idx, next_idx;
  logic first_ok, next_ok, rdy, timed_out;
  logic [NUM_VOICES-1:0] en_q;
  logic [17:0] acc, acc_nxt;
  logic [CW-1:0] cnt;
  logic [15:0] smp;
  // Downward scans leave the lowest qualifying index as the winner.
  always_comb begin
    first_idx = '0;
    first_ok = 1'b0;
    next_idx = '0;
    next_ok = 1'b0;
    smp = '0;
    rdy = 1'b0;
    voice_gen = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_en[i]) begin
        first_idx = IW'(i);
        first_ok = 1'b1;
      end
      if (en_q[i] && i > int'(cur)) begin
        next_idx = IW'(i);
        next_ok = 1'b1;
      end
      if (cur == IW'(i)) begin
        smp = voice_samples[16*i +: 16];
        rdy = voice_ready[i];
        voice_gen[i] = state == ISSUE;
      end
    end
  end
  assign timed_out = cnt == CW'(TIMEOUT - 1);
  assign acc_nxt = acc + (rdy ? {{2{smp[15]}}, smp} : 18'd0);
  assign mix_ready = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cur <= '0;
      en_q <= '0;
      acc <= '0;
      cnt <= '0;
      mix_sample <= '0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (generate_next && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (generate_next) begin
          en_q <= voice_en;
          acc <= '0;
          cur <= first_idx;
          state <= first_ok ? ISSUE : DONE;
          if (!first_ok) mix_sample <= '0;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (rdy || timed_out) begin
          acc <= acc_nxt;
          if (!rdy) timeout_err <= 1'b1;
          if (next_ok) begin
            cur <= next_idx;
            state <= ISSUE;
          end else begin
            mix_sample <= acc_nxt[17:2];
            state <= DONE;
          end
        end else cnt <= cnt + 1'b1;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chord_scheduler.sv
// tb_chord_scheduler: directed checks of chord_scheduler against 3-cycle-latency reader models.
module tb_chord_scheduler;
  logic clk = 0, reset = 1, generate_next = 0;
  logic [2:0] voice_en = 0, voice_gen, voice_ready, mute = 0;
  logic [47:0] voice_samples = 0;
  logic [15:0] mix_sample;
  logic mix_ready, busy, overrun, timeout_err;
  int vectors = 0, miscompares = 0;
  bit [2:0] sh [3];
  int ng, mr_cyc, mr_cnt, to_cyc;
  logic [2:0] gv [8];
  int gk [8];
  logic [15:0] mr_smp;
  logic busy_ok;
  always #5 clk = ~clk;
  chord_scheduler dut (
    .clk(clk), .reset(reset), .generate_next(generate_next), .voice_en(voice_en),
    .voice_gen(voice_gen), .voice_ready(voice_ready), .voice_samples(voice_samples),
    .mix_sample(mix_sample), .mix_ready(mix_ready), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err)
  );
  // A reader raises ready three edges after it samples its generate pulse.
  always @(posedge clk) for (int i = 0; i < 3; i++) sh[i] <= {sh[i][1:0], voice_gen[i]};
  always_comb for (int i = 0; i < 3; i++) voice_ready[i] = sh[i][2] & ~mute[i];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
  endtask
  task automatic run(input int ovr_at, input int chg_at, input int rst_at);
    ng = 0; mr_cyc = 0; mr_cnt = 0; to_cyc = 0; busy_ok = 1; mr_smp = 0;
    for (int i = 0; i < 8; i++) begin
      gv[i] = 0;
      gk[i] = 0;
    end
    @(negedge clk) generate_next = 1;
    @(posedge clk);
    #1 generate_next = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mr_cnt == 0 && !busy) busy_ok = 0;
      if (voice_gen != 0 && ng < 8) begin
        gv[ng] = voice_gen;
        gk[ng] = k;
        ng++;
      end
      if (mix_ready) begin
        if (mr_cnt == 0) begin
          mr_cyc = k;
          mr_smp = mix_sample;
        end
        mr_cnt++;
      end
      if (timeout_err && to_cyc == 0) to_cyc = k;
      generate_next = k == ovr_at;
      if (k == chg_at) voice_en = 0;
      if (k == rst_at) begin
        reset = 1;
        #1;
        chk("rst_mid_gen", voice_gen, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", mix_ready, 0);
        chk("rst_mid_sample", mix_sample, 0);
        chk("rst_mid_overrun", overrun, 0);
      end
      if (rst_at > 0 && k == rst_at + 1) reset = 0;
    end
  endtask
  task automatic check_full(input string t);
    chk({t, "_ngen"}, ng, 3);
    chk({t, "_gen0"}, {gv[0], 8'(gk[0])}, {3'b001, 8'd1});
    chk({t, "_gen1"}, {gv[1], 8'(gk[1])}, {3'b010, 8'd5});
    chk({t, "_gen2"}, {gv[2], 8'(gk[2])}, {3'b100, 8'd9});
    chk({t, "_mr_cyc"}, mr_cyc, 13);
    chk({t, "_mr_cnt"}, mr_cnt, 1);
    chk({t, "_sample"}, mr_smp, 16'h0E00);
    chk({t, "_held"}, mix_sample, 16'h0E00);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gen", voice_gen, 0);
    chk("rst_ready", mix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample", mix_sample, 0);
    chk("rst_flags", {overrun, timeout_err}, 0);
    @(negedge clk) reset = 0;
    repeat (3) @(negedge clk);
    voice_en = 3'b111;
    voice_samples = {16'h0800, 16'h2000, 16'h1000};
    run(0, 0, 0);
    check_full("t1");
    chk("t1_flags", {overrun, timeout_err}, 0);
    voice_en = 3'b101;
    voice_samples = {16'h8000, 16'h7FFF, 16'h8000};
    run(0, 0, 0);
    chk("t2_ngen", ng, 2);
    chk("t2_gen0", {gv[0], 8'(gk[0])}, {3'b001, 8'd1});
    chk("t2_gen1", {gv[1], 8'(gk[1])}, {3'b100, 8'd5});
    chk("t2_mr_cyc", mr_cyc, 9);
    chk("t2_sample", mr_smp, 16'hC000);
    voice_en = 3'b000;
    run(0, 0, 0);
    chk("t3_ngen", ng, 0);
    chk("t3_mr_cyc", mr_cyc, 1);
    chk("t3_sample", mr_smp, 0);
    voice_en = 3'b111;
    mute = 3'b010;
    voice_samples = {16'h0400, 16'h1234, 16'h0400};
    run(0, 0, 0);
    chk("t4_ngen", ng, 3);
    chk("t4_gen2", {gv[2], 8'(gk[2])}, {3'b100, 8'd22});
    chk("t4_to_cyc", to_cyc, 22);
    chk("t4_mr_cyc", mr_cyc, 26);
    chk("t4_sample", mr_smp, 16'h0200);
    chk("t4_sticky", timeout_err, 1);
    mute = 0;
    do_reset();
    chk("t4_cleared", timeout_err, 0);
    voice_samples = {16'h0800, 16'h2000, 16'h1000};
    run(3, 2, 0);
    voice_en = 3'b111;
    check_full("t5");
    chk("t5_overrun", overrun, 1);
    chk("t5_busy", busy_ok, 1);
    run(0, 0, 6);
    chk("t6_no_mr", mr_cnt, 0);
    run(0, 0, 0);
    check_full("t6b");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
